// File: rtl/psum_ofifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_ofifo_pkg : shared defaults for the per-column output FIFO      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package psum_ofifo_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 64;

endpackage : psum_ofifo_pkg
`default_nettype wire

// File: rtl/psum_ofifo_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ofifo_lane : single-column show-ahead FIFO with sticky overflow flag |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ofifo_lane
  import psum_ofifo_pkg::*;
#(
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [PSUM_BW-1:0] din,
  input  logic               rd,
  output logic [PSUM_BW-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               ovf
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]        wptr_q, wptr_d;
  logic [AW:0]        rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic [PSUM_BW-1:0] mem_q [DEPTH];
  logic               do_wr;
  logic               do_rd;

  // One extra pointer bit separates the full case from the empty case.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (do_wr) wptr_d = wptr_q + PTR_ONE;
    if (do_rd) rptr_d = rptr_q + PTR_ONE;
    if (wr && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= din;
  end

  assign dout = mem_q[rptr_q[AW-1:0]];
  assign ovf  = ovf_q;

endmodule : ofifo_lane
`default_nettype wire

// File: rtl/psum_ofifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_ofifo : per-column FIFOs that deskew the MAC array wavefront    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic [COL-1:0]         wr,
  input  logic                   rd,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  logic [COL-1:0] lane_empty;
  logic [COL-1:0] lane_full;
  logic [COL-1:0] lane_ovf;
  logic           pop;
  logic           unf_q, unf_d;

  generate
    for (genvar c = 0; c < COL; c++) begin : g_lane
      ofifo_lane #(
        .PSUM_BW (PSUM_BW),
        .DEPTH   (DEPTH)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .wr    (wr[c]),
        .din   (in[c*PSUM_BW +: PSUM_BW]),
        .rd    (pop),
        .dout  (out[c*PSUM_BW +: PSUM_BW]),
        .empty (lane_empty[c]),
        .full  (lane_full[c]),
        .ovf   (lane_ovf[c])
      );
    end
  endgenerate

  // Pop is all-or-nothing across lanes to keep the columns aligned.
  assign o_valid     = ~|lane_empty;
  assign o_full      = |lane_full;
  assign o_ready     = ~o_full;
  assign pop         = rd && o_valid;
  assign o_overflow  = |lane_ovf;
  assign o_underflow = unf_q;

  always_comb begin
    unf_d = unf_q;
    if (rd && !o_valid) unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) unf_q <= 1'b0;
    else       unf_q <= unf_d;
  end

endmodule : psum_ofifo
`default_nettype wire

// File: tb/tb_psum_ofifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_psum_ofifo : queue-model scoreboard bench for psum_ofifo          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_psum_ofifo;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 64;
  localparam int WW      = COL*PSUM_BW;

  logic           clk;
  logic           reset;
  logic [WW-1:0]  tb_in;
  logic [COL-1:0] tb_wr;
  logic           tb_rd;
  logic [WW-1:0]  tb_out;
  logic           o_valid, o_full, o_ready, o_overflow, o_underflow;

  psum_ofifo #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (tb_in),
    .wr          (tb_wr),
    .rd          (tb_rd),
    .out         (tb_out),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_ready     (o_ready),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // Reference model: one queue per column plus sticky flags.
  logic [PSUM_BW-1:0] mq [COL][$];
  logic [WW-1:0]      exp_q [$];
  logic               m_ovf, m_unf;
  logic               cur_valid, cur_full, cur_ovf, cur_unf;
  logic               mon_en = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic mvalid();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Drives one cycle from just after a rising edge; the model advances alongside.
  task automatic step(input logic [COL-1:0] w, input logic [WW-1:0] d, input logic r);
    logic           mv;
    logic [COL-1:0] fullv;
    logic [WW-1:0]  head;
    mv = mvalid();
    for (int c = 0; c < COL; c++) fullv[c] = (mq[c].size() == DEPTH);
    cur_valid = mv;
    cur_full  = |fullv;
    cur_ovf   = m_ovf;
    cur_unf   = m_unf;
    tb_wr = w; tb_in = d; tb_rd = r;
    if (r) begin
      if (mv) begin
        for (int c = 0; c < COL; c++) head[c*PSUM_BW +: PSUM_BW] = mq[c].pop_front();
        exp_q.push_back(head);
      end else m_unf = 1'b1;
    end
    for (int c = 0; c < COL; c++) begin
      if (w[c]) begin
        if (fullv[c]) m_ovf = 1'b1;
        else mq[c].push_back(d[c*PSUM_BW +: PSUM_BW]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    tb_wr = '0; tb_rd = 1'b0;
    for (int c = 0; c < COL; c++) mq[c].delete();
    exp_q.delete();
    m_ovf = 0; m_unf = 0;
    cur_valid = 0; cur_full = 0; cur_ovf = 0; cur_unf = 0;
    #1;
    chk("rst_valid", WW'(o_valid), WW'(0));
    chk("rst_full", WW'(o_full), WW'(0));
    chk("rst_ready", WW'(o_ready), WW'(1));
    chk("rst_ovf", WW'(o_overflow), WW'(0));
    chk("rst_unf", WW'(o_underflow), WW'(0));
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 4*DEPTH && mvalid(); n++) step('0, '0, 1'b1);
    step('0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("o_valid", WW'(o_valid), WW'(cur_valid));
      chk("o_full", WW'(o_full), WW'(cur_full));
      chk("o_ready", WW'(o_ready), WW'(!cur_full));
      chk("o_overflow", WW'(o_overflow), WW'(cur_ovf));
      chk("o_underflow", WW'(o_underflow), WW'(cur_unf));
      if (tb_rd && o_valid) begin
        pops++;
        if (exp_q.size() == 0) chk("unexpected_pop", WW'(1), WW'(0));
        else chk("pop_data", tb_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WW-1:0] d;
    reset = 1'b0; tb_wr = '0; tb_rd = 1'b0; tb_in = '0;
    async_reset();
    mon_en = 1'b1;

    // Skewed fill: o_valid rises only after the last column lands.
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(16'h0100 + c);
      step(COL'(1) << c, d, 1'b0);
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);

    // Streaming with one cycle of skew per column, rd whenever valid.
    pops = 0;
    for (int t = 0; t < 20 + COL; t++) begin
      logic [COL-1:0] w;
      w = '0; d = '0;
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c < 20) begin
          w[c] = 1'b1;
          d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(t - c + 1);
        end
      end
      step(w, d, mvalid());
    end
    drain();
    chk("stream_pops", WW'(pops), WW'(20));

    // Fill lane 3 to the brim, then one write too many.
    for (int i = 0; i < DEPTH + 1; i++) step(COL'(8), rand_word(), 1'b0);
    for (int i = 0; i < DEPTH; i++) step(COL'(8'hF7), rand_word(), 1'b0);
    // All lanes full: the pop happens, the writes are dropped.
    step('1, rand_word(), 1'b1);
    drain();

    // Underflow, then a normal fill leaving ten entries held.
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    for (int i = 0; i < 13; i++) step('1, rand_word(), 1'b0);
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1);
    async_reset();
    for (int i = 0; i < 5; i++) step('1, rand_word(), 1'b0);
    drain();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++)
      step(COL'($urandom | $urandom), rand_word(), 1'($urandom_range(0, 1)));
    drain();
    chk("scoreboard_empty", WW'(exp_q.size()), WW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_psum_ofifo
`default_nettype wire

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output collection stage directly downstream of the MAC array row chain.
- Each array column presents a psum_bw-wide result on its south edge, with a per-column valid strobe that fires independently as the skewed wavefront exits. This block holds one FIFO per column and absorbs that skew.
- It presents a complete, column-aligned output word only when every column has data, for the SFU/accumulation stage or the testbench readout.

Parameters:
- col, 8, number of array columns (independent FIFO lanes)
- psum_bw, 16, width of one column result
- depth, 64, entries per lane; must be a power of two, minimum 2
- aw, $clog2(depth), pointer index width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  col*psum_bw  column results; lane c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- wr  input  col  per-lane write strobe; bit c connects to valid[c] of the last array row
- rd  input  1  pop request for one aligned output word
- out  output  col*psum_bw  head entry of every lane, same lane packing as in
- o_valid  output  1  all lanes non-empty; out holds a complete aligned word
- o_full  output  1  at least one lane is full
- o_ready  output  1  no lane is full (equals ~o_full)
- o_overflow  output  1  sticky: a write was attempted to a full lane
- o_underflow  output  1  sticky: rd was asserted while o_valid was low

Behaviour:
- Each lane has a write pointer and a read pointer, each aw+1 bits wide.
  - Lane empty: wptr == rptr.
  - Lane full: MSBs differ and the low aw bits are equal.
  - Memory index is the low aw bits. Pointers wrap naturally modulo 2*depth.
- Reset asserted (async):
  - All pointers go to 0 and both sticky flags clear.
  - Outputs: o_valid=0, o_full=0, o_ready=1, o_overflow=0, o_underflow=0.
  - Memory contents are not reset. out equals mem[0] of each lane and is don't-care while o_valid=0.
  - Reset mid-operation discards all stored data. The first write after reset deassertion is accepted on the next clock edge.
- Write, lane c:
  - If wr[c]=1 and lane c is not full at the clock edge, store in[c] at wptr and increment wptr.
  - If wr[c]=1 and lane c is full, drop the data, leave wptr unchanged, and set o_overflow.
  - Lanes are written independently; any subset of wr may be set in one cycle.
- Read:
  - If rd=1 and o_valid=1, every lane's rptr increments in the same cycle. This is an all-or-nothing pop.
  - If rd=1 and o_valid=0, no pointer moves and o_underflow is set.
- Output:
  - Show-ahead: out is mem[rptr] of each lane, driven combinationally from storage.
  - A write to an empty lane becomes visible on out, and counts toward o_valid, in the cycle after the write edge. There is no bypass.
- Simultaneous read and write on a lane:
  - Full and empty are evaluated from pre-edge pointer values.
  - A full lane refuses the write even if a pop occurs in the same cycle (overflow is flagged).
  - A non-full lane performs both: occupancy is unchanged and data ordering is preserved.
- Flag timing:
  - o_full, o_ready and o_valid are combinational from the registered pointers, so they change only after clock edges or reset.
  - o_overflow and o_underflow are registered. They clear only on reset.

Decomposition:
- Shared package: no typedefs are required. Pointer width aw is derived locally with $clog2.
- Sub-module ofifo_lane: one single-column FIFO.
  - Ports: clk, reset, wr, din, rd, dout, empty, full, ovf.
  - Generated col times.
- The top level handles only:
  - AND-reduction of the lane non-empty signals into o_valid;
  - OR-reduction of the lane full signals into o_full;
  - gating of the broadcast pop;
  - the underflow flag.

Test Plan:
- Skewed fill: lane c written with 16'h0100+c at cycle c, for c=0..7. Required: o_valid stays 0 until the cycle after lane 7's write, then out = {16'h0107,...,16'h0100}. Assert rd for one cycle: o_valid returns to 0.
- Streaming: each lane written with 1..20 on consecutive cycles, skewed by one cycle per column, with rd held high whenever o_valid=1. Required: exactly 20 pops in order 1..20 on every lane, no flags set.
- Full/overflow: write 64 words to lane 3 only. Required: o_full=1, o_ready=0. A 65th write sets o_overflow=1 and lane 3 still pops the original 64 values in order.
- Full with simultaneous read/write: all lanes full and rd=1 with wr=8'hFF. Required: pop occurs, writes are dropped, o_overflow=1, o_full=0 next cycle.
- Underflow: rd=1 on an empty FIFO. Required: o_underflow=1, pointers unchanged, and a subsequent fill and pop behave normally.
- Reset mid-operation: assert reset asynchronously (between clock edges) with 10 entries held. Required: o_valid=0 and flags cleared immediately; after release, a fresh fill returns only new data.
